uart_rx_axis: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. Accepts its one-cycle `rx_valid`/`rx_data` byte pulses, queues the bytes in a first-word-fall-through FIFO, and presents them as an AXI4-Stream master toward the fabric. Flags overruns with a sticky flag. Optionally frames packets by asserting TLAST after a configurable line-idle gap.

---
 rtl/uart_rx_axis.sv | 120 ++++++++++++
 tb/tb_uart_rx_axis.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// UART receive buffer: byte strobes into a FWFT FIFO, drained as an AXI4-Stream master.
// Define UART_AXIS_TLAST_EN to close packets with TLAST after an idle gap of IDLE_TIMEOUT cycles.
module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS:0]   head;
    logic                 push;
    logic                 push_last;
    logic [DATA_BITS-1:0] push_data;
    logic                 pop;
    logic                 full;
    logic                 wr_en;

`ifdef UART_AXIS_TLAST_EN
    localparam int TW = $clog2(IDLE_TIMEOUT);

    logic                 stg_valid;
    logic [DATA_BITS-1:0] stg_data;
    logic [TW-1:0]        timer;
    logic                 timeout;

    // A new byte always wins over a timeout landing on the same cycle
    assign timeout   = stg_valid && !rx_valid && (timer == TW'(IDLE_TIMEOUT - 1));
    assign push      = (rx_valid && stg_valid) || timeout;
    assign push_last = timeout;
    assign push_data = stg_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            timer     <= '0;
        end else if (rx_valid) begin
            stg_valid <= 1'b1;
            stg_data  <= rx_data;
            timer     <= '0;
        end else if (stg_valid) begin
            if (timeout) begin
                stg_valid <= 1'b0;
                timer     <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign m_axis_tlast = m_axis_tvalid && head[DATA_BITS];
`else
    logic unused_cfg;

    assign push         = rx_valid;
    assign push_last    = 1'b0;
    assign push_data    = rx_data;
    assign m_axis_tlast = 1'b0;
    assign unused_cfg   = head[DATA_BITS] ^ (IDLE_TIMEOUT < 2);
`endif

    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop   = m_axis_tvalid && m_axis_tready;
    // When full, a push is only accepted if a pop frees the slot this cycle
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: vector table plus hand-written
// overflow, full push/pop, TLAST timeout and async reset sequences.
module tb_uart_rx_axis;

    localparam int DB = 8;
    localparam int D  = 16;
    localparam int T  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DB-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [DB-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic [CW-1:0] count;
    logic          ovf;
    logic          clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_axis #(
        .DATA_BITS   (DB),
        .FIFO_DEPTH  (D),
        .IDLE_TIMEOUT(T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .fifo_count    (count),
        .overflow      (ovf),
        .clear_overflow(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic [DB-1:0] d;
        logic          tr;
        logic          cl;
        logic          tv;
        logic [DB-1:0] td;
        logic [CW-1:0] cnt;
        logic          ov;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [DB-1:0] d,
                         input logic tr, input logic cl);
        rx_valid = rv;
        rx_data  = d;
        tready   = tr;
        clr      = cl;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tvalid"}, 32'(tvalid), 0);
        chk({nm, "_tdata"}, 32'(tdata), 0);
        chk({nm, "_tlast"}, 32'(tlast), 0);
        chk({nm, "_count"}, 32'(count), 0);
        chk({nm, "_ovf"}, 32'(ovf), 0);
    endtask

    initial begin
        vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vt[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
        vt[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0};
        vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

        #12;
        chk_zero("reset");
        rst = 1'b0;
        cyc();

`ifndef UART_AXIS_TLAST_EN
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rv, vt[i].d, vt[i].tr, vt[i].cl);
            cyc();
            chk($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vt[i].tv));
            chk($sformatf("vec%0d_tdata", i), 32'(tdata), 32'(vt[i].td));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
        end
        drive(0, 0, 0, 0);

        // fill past full with tready low
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'(i), 0, 0);
            cyc();
            if (i == 15) begin
                chk("fill16_ovf", 32'(ovf), 0);
            end
        end
        chk("fill_count", 32'(count), 16);
        chk("fill_ovf", 32'(ovf), 1);
        chk("fill_head", 32'(tdata), 0);
        drive(1, 8'h99, 0, 1);
        cyc();
        chk("ovf_set_beats_clear", 32'(ovf), 1);
        chk("ovf_drop_count", 32'(count), 16);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), 32'(tdata), 32'(i));
            cyc();
        end
        chk("drain_tvalid", 32'(tvalid), 0);
        chk("drain_ovf_sticky", 32'(ovf), 1);
        drive(0, 0, 0, 1);
        cyc();
        chk("ovf_cleared", 32'(ovf), 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            cyc();
        end
        chk("full_count", 32'(count), 16);
        drive(1, 8'h77, 1, 0);
        cyc();
        chk("pp_count", 32'(count), 16);
        chk("pp_ovf", 32'(ovf), 0);
        drive(0, 0, 1, 0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp_pop%0d", i), 32'(tdata), 32'(8'h40 + i));
            cyc();
        end
        chk("pp_last_data", 32'(tdata), 32'h77);
        chk("pp_last_count", 32'(count), 1);
        cyc();
        chk("pp_empty", 32'(tvalid), 0);
        drive(0, 0, 0, 0);
`else
        // bytes 3 cycles apart, tready low so the queue can be observed
        drive(1, 8'h01, 0, 0); cyc();
        drive(0, 0, 0, 0); cyc(); cyc();
        chk("stg_not_pushed", 32'(count), 0);
        drive(1, 8'h02, 0, 0); cyc();
        chk("b1_count", 32'(count), 1);
        chk("b1_data", 32'(tdata), 32'h01);
        chk("b1_tlast", 32'(tlast), 0);
        drive(0, 0, 0, 0); cyc(); cyc();
        drive(1, 8'h03, 0, 0); cyc();
        chk("b2_count", 32'(count), 2);
        drive(0, 0, 0, 0);
        for (int k = 1; k <= T; k++) begin
            cyc();
            if (k == T - 1) begin
                chk("b3_early", 32'(count), 2);
            end
        end
        chk("b3_timeout_count", 32'(count), 3);
        drive(0, 0, 1, 0);
        chk("pop1_data", 32'(tdata), 32'h01); chk("pop1_last", 32'(tlast), 0); cyc();
        chk("pop2_data", 32'(tdata), 32'h02); chk("pop2_last", 32'(tlast), 0); cyc();
        chk("pop3_data", 32'(tdata), 32'h03); chk("pop3_last", 32'(tlast), 1); cyc();
        chk("pop_empty", 32'(tvalid), 0);

        // new byte on the exact timeout cycle
        drive(1, 8'h04, 0, 0); cyc();
        drive(0, 0, 0, 0);
        for (int k = 1; k < T; k++) cyc();
        chk("edge_none_yet", 32'(count), 0);
        drive(1, 8'h05, 0, 0); cyc();
        chk("edge_count", 32'(count), 1);
        chk("edge_data", 32'(tdata), 32'h04);
        chk("edge_tlast", 32'(tlast), 0);
        drive(0, 0, 0, 0);
        for (int k = 1; k <= T; k++) cyc();
        chk("edge_b5_count", 32'(count), 2);
        drive(0, 0, 1, 0); cyc();
        chk("edge_b5_data", 32'(tdata), 32'h05);
        chk("edge_b5_last", 32'(tlast), 1);
        cyc();
        drive(0, 0, 0, 0);
`endif

        // reset mid-operation
`ifdef UART_AXIS_TLAST_EN
        for (int i = 0; i < 6; i++) begin
`else
        for (int i = 0; i < 5; i++) begin
`endif
            drive(1, 8'(8'hB0 + i), 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 5);
        #3 rst = 1'b1;
        #1;
        chk_zero("async_rst");
        #2 rst = 1'b0;
        cyc();
        drive(1, 8'h3C, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 3 * T && !tvalid; k++) cyc();
        chk("rst_recover_tvalid", 32'(tvalid), 1);
        chk("rst_recover_data", 32'(tdata), 32'h3C);
        chk("rst_recover_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
